// File: rtl/bram_responder.sv
// bram_responder: single-port BRAM responder for FSMD initiators.
// - 1-cycle registered, read-first read path (rdata <= mem[addr] every IDLE cycle).
// - Host load port (ld_valid/ld_ready), full-memory clear sequencer, saturating counters.
// - Optional macro BRAM_RESPONDER_PARITY_EN adds a per-word even-parity bit and a
//   sticky par_err flag; without it par_err is tied to 0.
//
// Handshake: a host load transfers on a rising edge where ld_valid && ld_ready are
// both high. ld_ready is combinational and never depends on ld_valid; the host must
// hold ld_valid/ld_addr/ld_data stable until the transfer edge.
// Write priority per cycle: clear sequencer (CLEAR) > initiator write > host load.
// The FSM state is visible as the internal signal `state` (busy mirrors CLEAR).
module bram_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  output logic [15:0]       wr_count,
  output logic [7:0]        drop_count,
  output logic              par_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Single merged write port so the array maps onto one BRAM port.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ld_ready = (state == IDLE) && !we && !clr_start && !reset;

  // Select which requester owns the write port this cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (!reset) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else if (we) begin
        mem_we    = 1'b1;
        mem_waddr = addr;
        mem_wdata = wdata;
      end else if (ld_valid && ld_ready) begin
        mem_we    = 1'b1;
        mem_waddr = ld_addr;
        mem_wdata = ld_data;
      end
    end
  end

  // Memory array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM: read path, clear sequencing and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clr_addr   <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      clr_done   <= 1'b0;
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          // Old contents are returned even when the same address is written.
          rdata <= mem[addr];
          if (we && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
          end
          if (clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          rdata <= '0;
          if (we && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
          end
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRAM_RESPONDER_PARITY_EN
  logic par_mem [DEPTH];

  // Parity bit travels with every data write (zero data gives parity 0).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_waddr] <= ^mem_wdata;
    end
  end

  // Sticky parity check on every IDLE read, aligned with the rdata update.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if ((state == IDLE) && ((^mem[addr]) != par_mem[addr])) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Memory-side responder for the synchronous single-port BRAM interface driven by the team's FSMD initiators: `addr`, `we`, write data and read data.
- Holds DEPTH words with 1-cycle registered read latency, matching an initiator that issues an address in its READ state and consumes `data_in` in its PROC state.
- Adds a host load port with a valid/ready handshake, a full-memory clear sequencer and a saturating write counter.
- Sits between the processing FSMD and the top-level host/testbench.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 16, word width.
- DEPTH, 256, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- addr  input  ADDR_W  initiator address.
- we  input  1  initiator write enable.
- wdata  input  DATA_W  initiator write data (driven by the initiator's `data_out`).
- rdata  output  DATA_W  registered read data (feeds the initiator's `data_in`).
- ld_valid  input  1  host load request.
- ld_ready  output  1  host load accepted this cycle.
- ld_addr  input  ADDR_W  host load address.
- ld_data  input  DATA_W  host load data.
- clr_start  input  1  request to zero the whole memory.
- busy  output  1  high while clearing.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_count  output  16  count of accepted initiator writes, saturating.
- drop_count  output  8  count of initiator writes dropped during CLEAR, saturating.
- par_err  output  1  sticky parity error; see Optional Feature.

Behaviour:
- Reset values (synchronous, `reset` high at a clock edge):
  - State goes to IDLE.
  - `rdata`, `wr_count`, `drop_count` = 0.
  - `busy`, `clr_done`, `par_err` = 0.
  - Internal clear address = 0.
  - Memory contents are not reset.
  - `ld_ready` = 0 while `reset` is high.
- States: IDLE and CLEAR.
- IDLE, every cycle:
  - Read-first: `rdata` <= mem[addr], the old contents even when `we`=1.
  - If `we`: mem[addr] <= wdata, and `wr_count` += 1, saturating at 0xFFFF.
- `ld_ready` is combinational: high only when state==IDLE && !we && !clr_start && !reset.
  - A load occurs when `ld_valid` && `ld_ready`: mem[ld_addr] <= ld_data.
  - A load does not change `rdata` or `wr_count`.
  - Priority is initiator write > clear request > host load.
- IDLE with `clr_start`=1: go to CLEAR at the next edge; clear address = 0.
  - A coincident initiator write in that cycle is still performed and counted.
- CLEAR, each cycle:
  - mem[clr_addr] <= 0 and clr_addr += 1.
  - `busy`=1.
  - `rdata` <= 0.
  - Initiator writes are ignored; `drop_count` += 1 per `we` cycle, saturating at 0xFF.
  - `clr_start` is ignored.
  - `ld_ready`=0.
- Clear completion:
  - The write at clr_addr==DEPTH-1 is the last one; that edge returns to IDLE and clr_addr wraps to 0.
  - `clr_done` pulses high for exactly 1 cycle with the first IDLE cycle, and `busy` drops at the same edge.
  - Total CLEAR duration is exactly DEPTH cycles (256 by default).
- Reset during CLEAR: immediate return to IDLE with `busy`=0 and no `clr_done` pulse. Words already cleared stay 0; the rest keep their old data.
- Address width: all address arithmetic is modulo DEPTH. No out-of-range case exists.

Optional Feature:
- Macro: BRAM_RESPONDER_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit (XOR of the data), written on initiator writes, host loads and clears (parity 0 for zero data).
  - Each IDLE read recomputes parity of the stored word against its stored bit.
  - A mismatch sets `par_err` on the same edge `rdata` updates.
  - `par_err` is cleared only by reset.
  - The bench injects errors through a hierarchical force on the parity array.
- When undefined: no parity storage; `par_err` is constant 0.

Test Plan:
- Reset, then check values: `rdata`=0, `busy`=0, `wr_count`=0, `drop_count`=0, `ld_ready`=1 while idle.
- Host load 0x1234 to address 5 with `we`=0 → one handshake cycle. Then `addr`=5, `we`=0 → `rdata`=0x1234 exactly one cycle later.
- Read-during-write: mem[7]=0x00AA, then `addr`=7, `we`=1, `wdata`=0x0055 → next cycle `rdata`=0x00AA, `wr_count`=1. A following read → 0x0055.
- Simultaneous `we`=1 and `ld_valid`=1 → `ld_ready`=0 and the load is stalled; it is accepted on the first cycle with `we`=0, and the host keeps `ld_valid`/`ld_addr`/`ld_data` stable until then.
- Clear sequence:
  - Pulse `clr_start` → `busy` high for 256 cycles, `clr_done` single pulse, and all 256 addresses read 0 afterwards.
  - 3 `we` cycles during CLEAR → `drop_count`=3 and `wr_count` unchanged.
  - Assert `reset` at clear cycle 100 → `busy`=0, no `clr_done`, address 150 keeps its prior value.
- Endurance run (saturation plus initiator loop):
  - 70000 initiator writes → `wr_count` holds 0xFFFF.
  - Full-sweep check with an FSMD initiator doing the read, +1, write loop over 256 words: every word is incremented by exactly 1.
